uart_rx_sched: RTL
==================

Name: uart_rx_sched

Overview:
Controller that sequences the oversampling UART receiver for the Viterbi decoder input path.
- Generates the 16x oversample tick.
- Gates the receiver enable.
- Captures each received word into the input FIFO.
- Counts words into fixed-length decoder blocks and hands each block to the decoder with a ready/ack handshake.
- Detects FIFO overrun and inter-word timeout.

Parameters:
SIZE_DATA, 16, receiver word width
CLK_DIV, 27, i_clk cycles per oversample tick (>=2)
BLOCK_LEN, 64, words per decoder block (>=1)
TIMEOUT_TICKS, 4096, oversample ticks allowed without a word while collecting

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  pulse: begin collecting one block; clears sticky flags
i_abort  in  1  pulse: cancel current block
i_rx_done  in  1  receiver word-complete pulse
i_rx_data  in  SIZE_DATA  receiver word, valid only while i_rx_done=1
i_fifo_full  in  1  input FIFO full
i_blk_ack  in  1  decoder accepted block
o_stick  out  1  oversample tick to receiver
o_rx_en  out  1  receiver enable
o_fifo_wr  out  1  FIFO write strobe
o_fifo_wdata  out  SIZE_DATA  FIFO write data
o_blk_ready  out  1  block complete, awaiting ack
o_busy  out  1  state != IDLE
o_word_cnt  out  $clog2(BLOCK_LEN+1)  words written in current block
o_overrun  out  1  sticky: word dropped on full FIFO
o_timeout  out  1  sticky: inter-word timeout

Behaviour:
Reset and clocking:
- Reset, asynchronous, active-low on i_rst_n; clock i_clk.
- All outputs 0 in reset; state IDLE; all counters 0.

Tick generator:
- Free-running divider 0..CLK_DIV-1.
- o_stick=1 for exactly one cycle when the divider equals CLK_DIV-1.
- Period CLK_DIV cycles, independent of state.

States:
- IDLE: o_rx_en=0. i_start -> COLLECT; clears o_word_cnt, o_overrun, o_timeout and the timeout counter.
- COLLECT: o_rx_en=1.
  - i_rx_done with i_fifo_full=0: capture i_rx_data; next cycle o_fifo_wr=1 for one cycle with the captured word (latency 1); o_word_cnt increments in that same cycle.
  - i_rx_done with i_fifo_full=1: word dropped, o_overrun<=1, count unchanged, collection continues.
  - o_word_cnt reaching BLOCK_LEN -> WAIT_ACK, in the cycle after the final write.
  - Timeout counter increments on each o_stick; cleared on each i_rx_done.
  - Timeout counter reaching TIMEOUT_TICKS -> ERROR, o_timeout<=1.
- WAIT_ACK: o_rx_en=0, o_blk_ready=1. i_blk_ack -> IDLE; o_blk_ready falls next cycle; o_word_cnt holds until the next i_start.
- ERROR: o_rx_en=0. i_start -> COLLECT (clears flags and count). i_abort -> IDLE.

Priorities and boundary cases:
- i_abort in any state -> IDLE next cycle; o_word_cnt cleared; sticky flags retained; a pending FIFO write already registered still completes.
- i_abort and i_start in the same cycle: abort wins.
- i_start in COLLECT or WAIT_ACK is ignored.
- i_rx_done outside COLLECT is ignored; no write.
- i_rx_done and timeout expiry in the same cycle: done wins; counter cleared; no ERROR.
- i_blk_ack outside WAIT_ACK is ignored.

Width rules:
- Counters saturate at their terminal value; they never wrap.
- o_fifo_wdata holds its last value when o_fifo_wr=0.

Optional Feature:
OVERRUN_HALT_EN
- Defined: an overrun additionally sends COLLECT -> ERROR the next cycle, with o_rx_en=0.
- Undefined: an overrun only sets o_overrun and collection continues.

Decomposition:
- Package uart_pkg: state enum (IDLE, COLLECT, WAIT_ACK, ERROR) and default SIZE_DATA/OVER_SAMPLE constants, shared with the receiver.
- One sub-module, baud_tick_gen (divider producing o_stick), parameterised by CLK_DIV.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=4, BLOCK_LEN=4, TIMEOUT_TICKS=32.
1. Reset, then idle 20 cycles -> o_stick pulses every 4th cycle; o_rx_en=0; o_busy=0; all flags 0.
2. i_start, then 4 i_rx_done pulses with data 0x1234, 0xABCD, 0x0000, 0xFFFF -> 4 single-cycle o_fifo_wr, each 1 cycle after its done, same data in order; o_word_cnt 1..4; o_blk_ready=1; i_blk_ack -> IDLE, o_blk_ready=0 next cycle.
3. Done pulse while i_fifo_full=1 -> no write, o_overrun=1, o_word_cnt unchanged; with OVERRUN_HALT_EN defined, state ERROR and o_rx_en=0.
4. i_start, one word, then no words for 32 ticks -> o_timeout=1, ERROR; i_start clears o_timeout and o_word_cnt=0 in COLLECT.
5. i_abort asserted with i_start, and i_abort mid-block after 2 words -> IDLE, o_word_cnt=0, o_rx_en=0 next cycle; o_overrun retained.
6. i_rx_done on the exact cycle the timeout counter hits 32 -> word written, no timeout, remains in COLLECT.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: scheduler state encoding and default word/oversample sizes.
package uart_pkg;

  localparam int unsigned SIZE_DATA_DEF = 16;
  localparam int unsigned OVER_SAMPLE   = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StCollect = 2'd1;
  localparam state_t StWaitAck = 2'd2;
  localparam state_t StError   = 2'd3;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider that emits one oversample tick every CLK_DIV clock cycles.
module baud_tick_gen #(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_stick
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  assign div_d   = (div_q == DivLast) ? '0 : div_q + 1'b1;
  assign o_stick = (div_q == DivLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_sched.sv
// Sequences the oversampling UART receiver into fixed-length decoder blocks.
// Define OVERRUN_HALT_EN to make a FIFO overrun abort collection into ERROR.
module uart_rx_sched
  import uart_pkg::*;
#(
  parameter int unsigned SIZE_DATA     = SIZE_DATA_DEF,
  parameter int unsigned CLK_DIV       = 27,
  parameter int unsigned BLOCK_LEN     = 64,
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic                             i_rx_done,
  input  logic [SIZE_DATA-1:0]             i_rx_data,
  input  logic                             i_fifo_full,
  input  logic                             i_blk_ack,
  output logic                             o_stick,
  output logic                             o_rx_en,
  output logic                             o_fifo_wr,
  output logic [SIZE_DATA-1:0]             o_fifo_wdata,
  output logic                             o_blk_ready,
  output logic                             o_busy,
  output logic [$clog2(BLOCK_LEN+1)-1:0]   o_word_cnt,
  output logic                             o_overrun,
  output logic                             o_timeout
);

  localparam int unsigned CntW = $clog2(BLOCK_LEN + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BLOCK_LEN);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_TICKS - 1);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_TICKS);

  logic                 stick;
  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ToW-1:0]       to_q, to_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic                 wr_q, wr_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;

  baud_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_stick(stick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;

    if (i_abort) begin
      // Sticky flags survive an abort; only the block count is dropped.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StError: begin
          if (i_start) begin
            state_d   = StCollect;
            cnt_d     = '0;
            to_d      = '0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
          end
        end
        StCollect: begin
          if (cnt_q == CntFull) begin
            state_d = StWaitAck;
          end else if (i_rx_done) begin
            // A word arriving on the expiry tick still counts as activity.
            to_d = '0;
            if (i_fifo_full) begin
              overrun_d = 1'b1;
`ifdef OVERRUN_HALT_EN
              state_d   = StError;
`endif
            end else begin
              wr_d    = 1'b1;
              wdata_d = i_rx_data;
              cnt_d   = cnt_q + 1'b1;
            end
          end else if (stick) begin
            if (to_q != ToMax) begin
              to_d = to_q + 1'b1;
            end
            if (to_q >= ToLast) begin
              state_d   = StError;
              timeout_d = 1'b1;
            end
          end
        end
        StWaitAck: begin
          if (i_blk_ack) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      to_q      <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_stick      = stick;
  assign o_rx_en      = (state_q == StCollect);
  assign o_blk_ready  = (state_q == StWaitAck);
  assign o_busy       = (state_q != StIdle);
  assign o_fifo_wr    = wr_q;
  assign o_fifo_wdata = wdata_q;
  assign o_word_cnt   = cnt_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule
